ws2812_tx: RTL and testbench



---
 rtl/ws2812_tx.sv | 161 ++++++++++++++++
 tb/tb_ws2812_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_tx.sv
// rtl/ws2812_tx.sv - WS2812 one-wire serial line driver fed by a pixel handshake
module ws2812_tx #(
  parameter int T0H          = 17,
  parameter int T1H          = 34,
  parameter int BIT_CYCLES   = 60,
  parameter int RESET_CYCLES = 2400,
  parameter int CW           = 16
) (
  input  logic        reset_n,
  input  logic        clk_sb,
  input  logic        send_leds_n,
  input  logic [23:0] rgb_data_in,
  output logic        next_led,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_BIT   = 3'd3,
    S_RST   = 3'd4
  } state_t;

  localparam logic [CW-1:0] T0H_C      = CW'(T0H);
  localparam logic [CW-1:0] T1H_C      = CW'(T1H);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] CYC_ONE    = CW'(1);
  localparam logic [4:0]    MSB_INDEX  = 5'd23;
  localparam logic [4:0]    BIT_ONE    = 5'd1;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [23:0]   shift_q, shift_d;

  logic          dout_q, dout_d;
  logic          next_led_q, next_led_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  logic [CW-1:0] high_len;

  // High time of the bit currently on the wire, chosen by the shift register MSB.
  always_comb begin
    high_len = shift_q[23] ? T1H_C : T0H_C;
  end

  // Next-state and next-output decode. dout and frame_done describe the cycle
  // just executed (one-cycle lag); next_led and busy describe the state being
  // entered, so the translator sees next_led while FETCH/prefetch is current.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    dout_d       = 1'b0;
    next_led_d   = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!send_leds_n) begin
          state_d    = S_FETCH;
          next_led_d = 1'b1;
        end
      end

      S_FETCH: begin
        state_d = S_LATCH;
      end

      S_LATCH: begin
        if (send_leds_n) begin
          // Request withdrawn before any pixel: zero-length frame.
          state_d = S_IDLE;
        end else begin
          shift_d   = rgb_data_in;
          bit_cnt_d = MSB_INDEX;
          cyc_d     = '0;
          state_d   = S_BIT;
        end
      end

      S_BIT: begin
        dout_d = (cyc_q < high_len);
        if (cyc_q == BIT_LAST) begin
          if (bit_cnt_q != 5'd0) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BIT_ONE;
            cyc_d     = '0;
            // Entering the last bit of the pixel: ask for the next word now so
            // it is stable well before the pixel boundary.
            if (bit_cnt_q == BIT_ONE) begin
              next_led_d = 1'b1;
            end
          end else if (!send_leds_n) begin
            // Back-to-back pixel, no gap on the wire.
            shift_d   = rgb_data_in;
            bit_cnt_d = MSB_INDEX;
            cyc_d     = '0;
          end else begin
            state_d = S_RST;
            cyc_d   = '0;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      S_RST: begin
        if (cyc_q == RST_LAST) begin
          state_d      = S_IDLE;
          cyc_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      dout_q       <= 1'b0;
      next_led_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      next_led_q   <= next_led_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout       = dout_q;
  assign next_led   = next_led_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// tb/tb_ws2812_tx.sv - directed self-checking bench for ws2812_tx
module tb_ws2812_tx;

  logic        reset_n;
  logic        clk_sb;
  logic        send_leds_n;
  logic [23:0] rgb_data_in;
  logic        next_led;
  logic        dout;
  logic        busy;
  logic        frame_done;

  ws2812_tx dut (
    .reset_n     (reset_n),
    .clk_sb      (clk_sb),
    .send_leds_n (send_leds_n),
    .rgb_data_in (rgb_data_in),
    .next_led    (next_led),
    .dout        (dout),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  typedef struct {
    int          n;
    logic [23:0] w0;
    logic [23:0] w1;
    logic [23:0] w2;
    int          exp_next;
    int          exp_rises;
    int          exp_done;
  } frame_vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc_cnt = 0;
  int          rise_q[$];
  int          hi_q[$];
  int          done_q[$];
  int          nl_q[$];
  int          n_busy = 0;
  int          hi_start = 0;
  logic        dout_prev;
  int          tr_en = 0;
  int          tr_n = 0;
  int          tr_pulses = 0;
  logic [23:0] tr_words [3];

  initial begin
    clk_sb = 1'b0;
    forever #5 clk_sb = ~clk_sb;
  end

  initial begin
    forever begin
      @(posedge clk_sb);
      cyc_cnt = cyc_cnt + 1;
    end
  end

  // Wire monitor: rise times, high lengths, pulses, busy cycles.
  initial begin
    dout_prev = 1'b0;
    forever begin
      @(negedge clk_sb);
      if (dout === 1'b1 && dout_prev === 1'b0) begin
        rise_q.push_back(cyc_cnt);
        hi_start = cyc_cnt;
      end
      if (dout === 1'b0 && dout_prev === 1'b1) hi_q.push_back(cyc_cnt - hi_start);
      if (next_led === 1'b1) nl_q.push_back(cyc_cnt);
      if (frame_done === 1'b1) done_q.push_back(cyc_cnt);
      if (busy === 1'b1) n_busy = n_busy + 1;
      dout_prev = dout;
    end
  end

  // Translator model: answers pulse k<=tr_n with word k-1, raises send_leds_n on the extra pulse.
  initial begin
    forever begin
      @(negedge clk_sb);
      if (tr_en != 0 && next_led === 1'b1) begin
        tr_pulses = tr_pulses + 1;
        @(posedge clk_sb);
        #1;
        if (tr_pulses <= tr_n) rgb_data_in = tr_words[tr_pulses-1];
        else send_leds_n = 1'b1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rise_q.delete();
    hi_q.delete();
    done_q.delete();
    nl_q.delete();
    n_busy = 0;
  endtask

  task automatic start_frame(input int n, input logic [23:0] w0, input logic [23:0] w1,
                             input logic [23:0] w2, output int start);
    clear_mon();
    tr_n = n;
    tr_words[0] = w0;
    tr_words[1] = w1;
    tr_words[2] = w2;
    tr_pulses = 0;
    tr_en = 1;
    @(posedge clk_sb);
    #1;
    start = cyc_cnt;
    send_leds_n = 1'b0;
  endtask

  task automatic wait_done(input int want, input string tag);
    for (int t = 0; t < 20000 && done_q.size() < want; t++) begin
      @(posedge clk_sb);
      #1;
    end
    check({tag, "_done_seen"}, (done_q.size() >= want) ? 1 : 0, 1);
  endtask

  task automatic check_word(input int base, input logic [23:0] word, input string tag);
    for (int i = 0; i < 24; i++) begin
      int exp_hi;
      int act_hi;
      exp_hi = word[23-i] ? 34 : 17;
      act_hi = (base + i < hi_q.size()) ? hi_q[base+i] : -1;
      check($sformatf("%s_bit%0d_high", tag, i), act_hi, exp_hi);
    end
  endtask

  task automatic run_frame(input frame_vec_t v, input string tag);
    int st;
    int last;
    start_frame(v.n, v.w0, v.w1, v.w2, st);
    wait_done(1, tag);
    repeat (3) @(posedge clk_sb);
    #1;
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_done_count"}, done_q.size(), 1);
    check({tag, "_next_led_count"}, nl_q.size(), v.exp_next);
    check({tag, "_rises"}, rise_q.size(), v.exp_rises);
    check({tag, "_first_rise_lat"}, (rise_q.size() > 0) ? rise_q[0] - st : -1, 4);
    check({tag, "_done_lat"}, (done_q.size() > 0) ? done_q[0] - st : -1, v.exp_done);
    last = rise_q.size() - 1;
    check({tag, "_rise_span"}, (last > 0) ? rise_q[last] - rise_q[0] : -1, 60 * (v.exp_rises - 1));
    check({tag, "_tail_to_done"}, (last >= 0 && done_q.size() > 0) ? done_q[0] - rise_q[last] : -1, 2459);
    for (int i = 0; i + 1 < rise_q.size(); i++) begin
      if (rise_q[i+1] - rise_q[i] != 60)
        check($sformatf("%s_period%0d", tag, i), rise_q[i+1] - rise_q[i], 60);
    end
    check_word(0, v.w0, {tag, "_px0"});
    if (v.n > 1) check_word(24, v.w1, {tag, "_px1"});
    if (v.n > 2) check_word(48, v.w2, {tag, "_px2"});
  endtask

  initial begin
    frame_vec_t vecs [3];
    frame_vec_t after_rst;
    int st;
    int ok;

    vecs[0]   = '{1, 24'hA50F3C, 24'h000000, 24'h000000, 2, 24, 3843};
    vecs[1]   = '{3, 24'hFF0000, 24'h00FF00, 24'h0000FF, 4, 72, 6723};
    vecs[2]   = '{2, 24'h000000, 24'hFFFFFF, 24'h000000, 3, 48, 5283};
    after_rst = '{1, 24'h5A5A5A, 24'h000000, 24'h000000, 2, 24, 3843};

    reset_n     = 1'b0;
    send_leds_n = 1'b1;
    rgb_data_in = 24'h0;
    repeat (3) @(posedge clk_sb);
    #1;
    check("reset_dout", int'(dout), 0);
    check("reset_next_led", int'(next_led), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_done", int'(frame_done), 0);
    #3 reset_n = 1'b1;
    repeat (2) @(posedge clk_sb);
    #1;
    check("idle_busy", int'(busy), 0);

    for (int k = 0; k < 3; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

    // Zero-length frame: request held for two sampled cycles only.
    clear_mon();
    tr_en = 0;
    @(posedge clk_sb);
    #1 send_leds_n = 1'b0;
    @(posedge clk_sb);
    @(posedge clk_sb);
    #1 send_leds_n = 1'b1;
    repeat (10) @(posedge clk_sb);
    #1;
    check("zero_next_led", nl_q.size(), 1);
    check("zero_rises", rise_q.size(), 0);
    check("zero_busy_cycles", n_busy, 2);
    check("zero_frame_done", done_q.size(), 0);

    // Request re-asserted during RST: next frame starts right after frame_done.
    start_frame(1, 24'h800001, 24'h0, 24'h0, st);
    ok = 0;
    for (int t = 0; t < 3000 && ok == 0; t++) begin
      @(posedge clk_sb);
      #1;
      if (send_leds_n === 1'b1) ok = 1;
    end
    check("cont_first_raise", ok, 1);
    repeat (200) @(posedge clk_sb);
    #1;
    tr_pulses = 0;
    send_leds_n = 1'b0;
    wait_done(2, "cont");
    repeat (3) @(posedge clk_sb);
    #1;
    check("cont_done_spacing", (done_q.size() > 1) ? done_q[1] - done_q[0] : -1, 3843);
    check("cont_fetch_after_done", (nl_q.size() > 2 && done_q.size() > 0) ? nl_q[2] - done_q[0] : -1, 1);
    check("cont_rises", rise_q.size(), 48);
    check("cont_rise_after_done", (rise_q.size() > 24 && done_q.size() > 0) ? rise_q[24] - done_q[0] : -1, 4);
    // Last bit is a 1: 26-cycle tail, 2400 RST cycles, then IDLE/FETCH/LATCH.
    check("cont_low_gap", (rise_q.size() > 24 && hi_q.size() > 23) ? rise_q[24] - rise_q[23] - hi_q[23] : -1, 2429);
    check_word(0, 24'h800001, "cont_f0");
    check_word(24, 24'h800001, "cont_f1");

    // Request withdrawn mid-pixel: pixel 1 finishes, pixel 2 is never sent.
    start_frame(2, 24'h123456, 24'hABCDEF, 24'h0, st);
    for (int t = 0; t < 2000 && rise_q.size() < 4; t++) begin
      @(posedge clk_sb);
      #1;
    end
    repeat (5) @(posedge clk_sb);
    #1 send_leds_n = 1'b1;
    wait_done(1, "mid");
    repeat (3) @(posedge clk_sb);
    #1;
    check("mid_rises", rise_q.size(), 24);
    check("mid_next_led", nl_q.size(), 2);
    check("mid_done_lat", (done_q.size() > 0) ? done_q[0] - st : -1, 3843);
    check_word(0, 24'h123456, "mid_px0");

    // Asynchronous reset during pixel 2 bit 12 while dout is high.
    start_frame(3, 24'hC3C3C3, 24'hFFFFFF, 24'h0F0F0F, st);
    for (int t = 0; t < 4000 && rise_q.size() < 36; t++) begin
      @(posedge clk_sb);
      #1;
    end
    @(posedge clk_sb);
    #2;
    check("rst_pre_dout", int'(dout), 1);
    check("rst_pre_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("rst_async_dout", int'(dout), 0);
    check("rst_async_next_led", int'(next_led), 0);
    check("rst_async_busy", int'(busy), 0);
    tr_en = 0;
    send_leds_n = 1'b1;
    repeat (3) @(posedge clk_sb);
    #1;
    check("rst_hold_busy", int'(busy), 0);
    @(negedge clk_sb);
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sb);
    run_frame(after_rst, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
